// File: rtl/btn_debounce_multi.sv
// Multi-channel button synchroniser/debouncer with press, release,
// long-press and (with BTN_REPEAT_EN) auto-repeat pulses per channel.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   i_btn   raw button levels, 1 = pressed
//   o_btn   debounced level per channel
//   o_rise  1-cycle pulse on accepted press
//   o_fall  1-cycle pulse on accepted release
//   o_long  1-cycle pulse when the hold reaches LONG_CYCLES
//   o_rep   1-cycle auto-repeat pulse (0 unless BTN_REPEAT_EN)
// Optional feature macro: BTN_REPEAT_EN
module btn_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_rep
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int LG_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_ONE  = LG_W'(1);
  localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

`ifdef BTN_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic            s1;
    logic            s2;
    state_t          st;
    logic [DB_W-1:0] db_cnt;
    logic [LG_W-1:0] hold_cnt;
    logic            btn_q;
    logic            rise_q;
    logic            fall_q;
    logic            long_q;
    logic            held;

    // Hold time only advances while the synchronised input is high in a
    // pressed state, so a release bounce pauses rather than restarts it.
    assign held = s2 && (st == PRESSED || st == RELEASE_WAIT);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= i_btn[g];
        s2 <= s1;
      end
    end

`ifdef BTN_REPEAT_EN
    logic            rep_on;
    logic [RP_W-1:0] rep_cnt;
    logic            rep_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st       <= IDLE;
        db_cnt   <= '0;
        hold_cnt <= '0;
        btn_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        long_q   <= 1'b0;
`ifdef BTN_REPEAT_EN
        rep_on   <= 1'b0;
        rep_cnt  <= '0;
        rep_q    <= 1'b0;
`endif
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
`ifdef BTN_REPEAT_EN
        rep_q  <= 1'b0;
`endif
        if (held) begin
          if (hold_cnt != LG_MAX)
            hold_cnt <= hold_cnt + LG_ONE;
          if (hold_cnt == LG_LAST)
            long_q <= 1'b1;
`ifdef BTN_REPEAT_EN
          if (rep_on) begin
            if (rep_cnt == RP_LAST) begin
              rep_cnt <= '0;
              rep_q   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RP_ONE;
            end
          end
          // Repeat period is timed from the long-press cycle.
          if (hold_cnt == LG_LAST) begin
            rep_on  <= 1'b1;
            rep_cnt <= '0;
          end
`endif
        end
        unique case (st)
          IDLE: begin
            if (s2) begin
              st     <= PRESS_WAIT;
              db_cnt <= DB_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s2) begin
              st     <= IDLE;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              st     <= PRESSED;
              db_cnt <= '0;
              btn_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          PRESSED: begin
            if (!s2) begin
              st     <= RELEASE_WAIT;
              db_cnt <= DB_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (s2) begin
              st     <= PRESSED;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              st       <= IDLE;
              db_cnt   <= '0;
              btn_q    <= 1'b0;
              fall_q   <= 1'b1;
              hold_cnt <= '0;
`ifdef BTN_REPEAT_EN
              rep_on   <= 1'b0;
              rep_cnt  <= '0;
`endif
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign o_btn[g]  = btn_q;
    assign o_rise[g] = rise_q;
    assign o_fall[g] = fall_q;
    assign o_long[g] = long_q;
`ifdef BTN_REPEAT_EN
    assign o_rep[g]  = rep_q;
`else
    assign o_rep[g]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: a run-length reference model
// predicts every output cycle; a monitor compares on the falling edge.
module tb_btn_debounce_multi;
  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_btn, o_rise, o_fall, o_long, o_rep;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .N_CH(N), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_btn(o_btn), .o_rise(o_rise), .o_fall(o_fall),
    .o_long(o_long), .o_rep(o_rep)
  );

  typedef struct packed {
    logic [N-1:0] btn;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] lng;
    logic [N-1:0] rep;
  } out_t;

  out_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int m_rise = 0, m_fall = 0, m_long = 0, m_rep = 0;
  int d_rise = 0, d_fall = 0, d_long = 0, d_rep = 0;

  // Reference model: s is the input seen two edges ago; a new level is
  // accepted after DB consecutive samples differing from the current one.
  logic [N-1:0] hist[$];
  bit m_lvl[N];
  int m_run[N];
  int m_hold[N];
  int m_repc[N];
  bit m_repon[N];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hist.delete();
      for (int c = 0; c < N; c++) begin
        m_lvl[c] = 0; m_run[c] = 0; m_hold[c] = 0;
        m_repc[c] = 0; m_repon[c] = 0;
      end
    end else begin
      out_t e;
      logic [N-1:0] s;
      hist.push_back(i_btn);
      if (hist.size() > 3) void'(hist.pop_front());
      s = (hist.size() == 3) ? hist[0] : '0;
      e = '0;
      for (int c = 0; c < N; c++) begin
        bit was;
        was = m_lvl[c];
        m_run[c] = (s[c] != was) ? m_run[c] + 1 : 0;
        if (was && s[c]) begin
          bit fired;
          fired = 0;
          if (m_hold[c] < LG) begin
            m_hold[c]++;
            if (m_hold[c] == LG) fired = 1;
          end
`ifdef BTN_REPEAT_EN
          if (m_repon[c]) begin
            m_repc[c]++;
            if (m_repc[c] == RP) begin
              e.rep[c] = 1'b1;
              m_repc[c] = 0;
            end
          end
          if (fired) begin
            m_repon[c] = 1;
            m_repc[c] = 0;
          end
`endif
          e.lng[c] = fired;
        end
        if (m_run[c] == DB) begin
          m_lvl[c] = !was;
          m_run[c] = 0;
          if (m_lvl[c]) e.rise[c] = 1'b1;
          else begin
            e.fall[c] = 1'b1;
            m_hold[c] = 0;
            m_repon[c] = 0;
            m_repc[c] = 0;
          end
        end
        e.btn[c] = m_lvl[c];
      end
      exp_q.push_back(e);
    end
  end

  initial forever begin
    out_t a;
    @(negedge clk);
    a = '{o_btn, o_rise, o_fall, o_long, o_rep};
    if (rst) begin
      exp_q.delete();
      checks++;
      if (a != '0) begin
        failures++;
        $display("FAIL reset_out t=%0t act=%h req=0", $time, a);
      end
    end else if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      checks++;
      if (a != e) begin
        failures++;
        $display("FAIL outputs t=%0t btn=%b/%b rise=%b/%b fall=%b/%b long=%b/%b rep=%b/%b (act/req)",
                 $time, a.btn, e.btn, a.rise, e.rise, a.fall, e.fall,
                 a.lng, e.lng, a.rep, e.rep);
      end
      m_rise += $countones(e.rise); d_rise += $countones(a.rise);
      m_fall += $countones(e.fall); d_fall += $countones(a.fall);
      m_long += $countones(e.lng);  d_long += $countones(a.lng);
      m_rep  += $countones(e.rep);  d_rep  += $countones(a.rep);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic tot(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  int rem[N];

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(3);
    // clean press on ch0
    i_btn[0] = 1'b1; cyc(30);
    i_btn[0] = 1'b0; cyc(15);
    // bounce: 3 cycles high / 3 low
    repeat (4) begin
      i_btn[0] = 1'b1; cyc(3);
      i_btn[0] = 1'b0; cyc(3);
    end
    i_btn[0] = 1'b1; cyc(12);
    i_btn[0] = 1'b0; cyc(12);
    // long press on ch1
    i_btn[1] = 1'b1; cyc(50);
    i_btn[1] = 1'b0; cyc(15);
    // 2-cycle release glitch during hold
    i_btn[0] = 1'b1; cyc(15);
    i_btn[0] = 1'b0; cyc(2);
    i_btn[0] = 1'b1; cyc(30);
    i_btn[0] = 1'b0; cyc(12);
    // async reset mid-hold with button still held
    i_btn[0] = 1'b1; cyc(20);
    #6 rst = 1'b1;
    #1;
    checks++;
    if ({o_btn, o_rise, o_fall, o_long, o_rep} != '0) begin
      failures++;
      $display("FAIL async_reset act=%h req=0",
               {o_btn, o_rise, o_fall, o_long, o_rep});
    end
    @(negedge clk); #2;
    cyc(1);
    rst = 1'b0;
    cyc(40);
    i_btn[0] = 1'b0; cyc(12);
    // long hold for auto-repeat
    i_btn = '1; cyc(100);
    i_btn = '0; cyc(12);
    // random segments per channel
    for (int c = 0; c < N; c++) rem[c] = 0;
    repeat (2500) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          i_btn[c] = ~i_btn[c];
          rem[c] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(20, 60)) :
                   int'($urandom_range(1, 6));
        end
        rem[c]--;
      end
      cyc(1);
    end
    i_btn = '0;
    cyc(20);
    tot("rise_total", d_rise, m_rise);
    tot("fall_total", d_fall, m_fall);
    tot("long_total", d_long, m_long);
    tot("rep_total", d_rep, m_rep);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
